pool_reduce_tree: RTL and testbench
===================================

Name: pool_reduce_tree

Overview:
Parametrised, pipelined N-input reduction tree for the pooling layers of the VGG16 datapath. It is the generalised successor to the fixed 9-input max-pool: any window size, any data width, and a per-beat mode of max, min or sum. It also reports the argmax/argmin position for unpooling, and uses ready/valid backpressure instead of externally supplied stage enables. It sits between the window/line-buffer generator and the pooled-feature writeback.

Parameters:
DATA_WIDTH, 32, width of each signed two's-complement element
N_IN, 9, number of window elements reduced per beat (legal range 2..64)
IDX_W, $clog2(N_IN), width of winner index output
LEVELS, $clog2(N_IN), pipeline depth, derived and not overridden

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat this cycle
in_data  in  N_IN*DATA_WIDTH  element k at bits [k*DATA_WIDTH +: DATA_WIDTH], k=0 is the window's first element
in_mode  in  2  00=max, 01=min, 10=sum, 11=reserved (treated as max)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  DATA_WIDTH  reduced result
out_idx  out  IDX_W  index k of the winning element (max/min); 0 in sum mode
out_sat  out  1  sum result was saturated (0 in max/min)

Behaviour:
- Tree structure:
  - Level 0 operates on the N_IN inputs; level j has ceil(n_(j-1)/2) nodes; there are LEVELS registered levels.
  - Node i of a level combines prev[2i] and prev[2i+1].
  - An unpaired last element passes through unchanged, with its index, into that level's register.
  - Example: N_IN=9 gives 5, 3, 2, 1 nodes.
- Each node carries value (DATA_WIDTH+LEVELS bits, sign-extended), index (IDX_W) and mode. Mode is sampled with the beat and travels with it, so mixed-mode beats may be in flight together.
- Max: larger signed value wins; on a tie the lower index (left operand) wins. Min: smaller wins, same tie rule. Result is exact, the index is that of the first occurrence.
- Sum:
  - Full-precision add at every level.
  - At the output, saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; out_sat=1 iff clamping occurred.
  - No intermediate overflow is possible.
- Pipeline advance: en = !out_valid || out_ready. in_ready = en && !rst.
  - When en=1 every level register and its valid bit shift one level.
  - When en=0 all levels hold.
  - Bubbles are not compressed.
- A beat is accepted when in_valid && in_ready. Latency is exactly LEVELS cycles from acceptance to out_valid when out_ready stays high; throughput is 1 beat/cycle.
- Outputs are registered (last tree level). out_data, out_idx and out_sat stay stable while out_valid && !out_ready.
- Reset (synchronous, active-high):
  - All valid bits, out_valid, out_data, out_idx and out_sat go to 0. in_ready=0 during the reset cycle.
  - Asserting reset mid-operation discards all in-flight beats; the first beat accepted after reset is the first beat output.
  - Data registers may be cleared or left as-is, but outputs must read 0 after reset.
- Simultaneous accept on input and drain on output in the same cycle is legal and loses no beats.
- in_valid=0 with en=1 injects a bubble (valid=0); out_valid reflects it LEVELS cycles later.

Test Plan:
1. N_IN=9, DATA_WIDTH=16, max mode, inputs {3,-7,12,0,12,5,-1,2,9}, out_ready=1 -> out_valid 4 cycles after acceptance, out_data=12, out_idx=2, out_sat=0.
2. Same config, min mode, inputs all 5 except element 8 = -32768 -> out_data=-32768, out_idx=8 (unpaired pass-through path).
3. Sum mode, nine inputs of 30000 -> out_data=32767, out_sat=1; nine inputs of -1 -> out_data=-9, out_sat=0, out_idx=0.
4. Back-to-back 20 beats with random modes, out_ready toggled at random ~50% -> results match the reference model in order, with no drops or duplicates; outputs are stable while stalled; in_ready equals !out_valid||out_ready.
5. Fill the pipeline with 4 beats, then assert rst for one cycle mid-stream -> out_valid=0 and outputs are 0 the next cycle; none of the pre-reset beats ever appear; the next accepted beat emerges after 4 cycles.
6. N_IN=2 and N_IN=16 builds with equal inputs {7,7,...} in max mode -> out_data=7, out_idx=0, latency 1 and 4 respectively.

Source files
------------

// File: rtl/pool_reduce_tree_if.sv
// Beat-level handshake bundle for pool_reduce_tree: window in, reduced result out.
// The slave modport is the reduction tree; master is the window generator / writeback side.
interface pool_reduce_tree_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_IN       = 9,
  parameter int IDX_W      = $clog2(N_IN)
);
  logic                         in_valid;
  logic                         in_ready;
  logic [N_IN*DATA_WIDTH-1:0]   in_data;
  logic [1:0]                   in_mode;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]             out_idx;
  logic                         out_sat;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_sat
  );
endinterface

// File: rtl/pool_reduce_tree.sv
// Pipelined N-input max/min/sum reduction tree with winner index and output saturation.
// One registered tree level per pipeline stage; the whole pipe advances or holds as a unit.
module pool_reduce_tree #(
  parameter int DATA_WIDTH = 32,
  parameter int N_IN       = 9,
  parameter int IDX_W      = $clog2(N_IN)
) (
  input logic               clk,
  input logic               rst,
  pool_reduce_tree_if.slave bus
);
  localparam int LEVELS = $clog2(N_IN);
  localparam int VAL_W  = DATA_WIDTH + LEVELS;
  localparam logic [1:0] MODE_MIN = 2'b01;
  localparam logic [1:0] MODE_SUM = 2'b10;

  typedef logic signed [VAL_W-1:0] val_t;

  localparam val_t SAT_MAX = val_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam val_t SAT_MIN = ~SAT_MAX;

  function automatic int nodes(input int lvl);
    return (N_IN + (1 << (lvl + 1)) - 1) >> (lvl + 1);
  endfunction

  // Strict compare keeps the left (lower-index) operand on ties.
  function automatic logic right_wins(input logic [1:0] m, input val_t a, input val_t b);
    if (m == MODE_MIN) return b < a;
    return b > a;
  endfunction

  function automatic logic sum_overflow(input val_t v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sum_clamp(input val_t v);
    if (v > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
  endfunction

  val_t             val_q  [LEVELS][N_IN];
  val_t             val_d  [LEVELS][N_IN];
  logic [IDX_W-1:0] idx_q  [LEVELS][N_IN];
  logic [IDX_W-1:0] idx_d  [LEVELS][N_IN];
  logic [1:0]       mode_q [LEVELS];
  logic [LEVELS-1:0] vld_q;

  logic en;
  logic out_vld;

  assign out_vld      = vld_q[LEVELS-1];
  assign en           = !out_vld || bus.out_ready;
  assign bus.in_ready = en && !rst;

  always_comb begin
    int np;
    int jp;
    int b;
    val_t va;
    val_t vb;
    logic [IDX_W-1:0] ia;
    logic [IDX_W-1:0] ib;
    logic [1:0] m;
    np = 0;
    jp = 0;
    b  = 0;
    va = '0;
    vb = '0;
    ia = '0;
    ib = '0;
    m  = '0;
    for (int j = 0; j < LEVELS; j++) begin
      for (int i = 0; i < N_IN; i++) begin
        val_d[j][i] = '0;
        idx_d[j][i] = '0;
      end
    end
    for (int j = 0; j < LEVELS; j++) begin
      jp = (j == 0) ? 0 : j - 1;
      np = (j == 0) ? N_IN : nodes(jp);
      m  = (j == 0) ? bus.in_mode : mode_q[jp];
      for (int i = 0; i < (N_IN + 1) / 2; i++) begin
        b = (2 * i + 1 < N_IN) ? 2 * i + 1 : 2 * i;
        if (j == 0) begin
          va = val_t'($signed(bus.in_data[2 * i * DATA_WIDTH +: DATA_WIDTH]));
          vb = val_t'($signed(bus.in_data[b * DATA_WIDTH +: DATA_WIDTH]));
          ia = IDX_W'(2 * i);
          ib = IDX_W'(b);
        end else begin
          va = val_q[jp][2 * i];
          vb = val_q[jp][b];
          ia = idx_q[jp][2 * i];
          ib = idx_q[jp][b];
        end
        if (i < nodes(j)) begin
          if (2 * i + 1 >= np) begin
            val_d[j][i] = va;
            idx_d[j][i] = ia;
          end else if (m == MODE_SUM) begin
            val_d[j][i] = va + vb;
            idx_d[j][i] = '0;
          end else if (right_wins(m, va, vb)) begin
            val_d[j][i] = vb;
            idx_d[j][i] = ib;
          end else begin
            val_d[j][i] = va;
            idx_d[j][i] = ia;
          end
        end
      end
    end
  end

  // Stage boundary: one tree level per register, valid bits travel with their level.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[0] <= bus.in_valid;
      for (int j = 1; j < LEVELS; j++) vld_q[j] <= vld_q[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      val_q     <= val_d;
      idx_q     <= idx_d;
      mode_q[0] <= bus.in_mode;
      for (int j = 1; j < LEVELS; j++) mode_q[j] <= mode_q[j-1];
    end
  end

  // Data regs are not reset, so results are gated by valid to read 0 when idle.
  val_t       fin_val;
  logic [1:0] fin_mode;
  assign fin_val  = val_q[LEVELS-1][0];
  assign fin_mode = mode_q[LEVELS-1];

  assign bus.out_valid = out_vld;
  assign bus.out_data  = !out_vld ? '0 :
                         (fin_mode == MODE_SUM) ? sum_clamp(fin_val) : fin_val[DATA_WIDTH-1:0];
  assign bus.out_idx   = (!out_vld || fin_mode == MODE_SUM) ? '0 : idx_q[LEVELS-1][0];
  assign bus.out_sat   = out_vld && (fin_mode == MODE_SUM) && sum_overflow(fin_val);
endmodule

// File: tb/tb_pool_reduce_tree.sv
// Directed bench for pool_reduce_tree: 9-input main build plus 2- and 16-input builds.
module tb_pool_reduce_tree;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pool_reduce_tree_if #(.DATA_WIDTH(16), .N_IN(9))  if9  ();
  pool_reduce_tree_if #(.DATA_WIDTH(16), .N_IN(2))  if2  ();
  pool_reduce_tree_if #(.DATA_WIDTH(16), .N_IN(16)) if16 ();

  pool_reduce_tree #(.DATA_WIDTH(16), .N_IN(9))  dut9  (.clk(clk), .rst(rst), .bus(if9.slave));
  pool_reduce_tree #(.DATA_WIDTH(16), .N_IN(2))  dut2  (.clk(clk), .rst(rst), .bus(if2.slave));
  pool_reduce_tree #(.DATA_WIDTH(16), .N_IN(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  typedef struct packed {
    logic signed [15:0] d;
    logic [3:0]         i;
    logic               s;
  } res_t;

  int         ev [16];
  int         rv [9];
  logic [1:0] rmode;
  res_t       exp_q [$];
  res_t       r;
  int         sent, got, cyc;
  logic       acc, stalled;
  longint     held_d, held_i, held_s;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pack_ev(input int n);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k*16 +: 16] = 16'(ev[k]);
    return v;
  endfunction

  function automatic logic vld_of(input int sel);
    case (sel)
      2:       return if2.out_valid;
      16:      return if16.out_valid;
      default: return if9.out_valid;
    endcase
  endfunction

  function automatic longint data_of(input int sel);
    case (sel)
      2:       return if2.out_data;
      16:      return if16.out_data;
      default: return if9.out_data;
    endcase
  endfunction

  function automatic longint idx_of(input int sel);
    case (sel)
      2:       return if2.out_idx;
      16:      return if16.out_idx;
      default: return if9.out_idx;
    endcase
  endfunction

  function automatic longint sat_of(input int sel);
    case (sel)
      2:       return if2.out_sat;
      16:      return if16.out_sat;
      default: return if9.out_sat;
    endcase
  endfunction

  // Independent linear-scan reference for the 9-input build.
  function automatic res_t model9(input int e[9], input logic [1:0] m);
    res_t rr;
    int best, bi, s;
    rr = '0;
    if (m == 2'b10) begin
      s = 0;
      for (int k = 0; k < 9; k++) s += e[k];
      if (s > 32767) begin
        rr.d = 16'sd32767; rr.s = 1'b1;
      end else if (s < -32768) begin
        rr.d = -16'sd32768; rr.s = 1'b1;
      end else begin
        rr.d = 16'(s);
      end
    end else begin
      best = e[0];
      bi   = 0;
      for (int k = 1; k < 9; k++) begin
        if ((m == 2'b01) ? (e[k] < best) : (e[k] > best)) begin
          best = e[k];
          bi   = k;
        end
      end
      rr.d = 16'(best);
      rr.i = 4'(bi);
    end
    return rr;
  endfunction

  task automatic new_beat9();
    for (int k = 0; k < 9; k++) begin
      rv[k] = int'($urandom_range(65535)) - 32768;
      if9.in_data[k*16 +: 16] = 16'(rv[k]);
    end
    rmode        = 2'($urandom_range(3));
    if9.in_mode  = rmode;
    if9.in_valid = 1'b1;
  endtask

  task automatic single(input int sel, input string tag, input logic [1:0] m, input int n,
                        input int exp_lat, input int ed, input int ei, input int es);
    int lat;
    logic [255:0] pk;
    pk = pack_ev(n);
    case (sel)
      2:       begin if2.in_data  = pk[31:0];  if2.in_mode  = m; if2.in_valid  = 1'b1; end
      16:      begin if16.in_data = pk[255:0]; if16.in_mode = m; if16.in_valid = 1'b1; end
      default: begin if9.in_data  = pk[143:0]; if9.in_mode  = m; if9.in_valid  = 1'b1; end
    endcase
    tick();
    if2.in_valid  = 1'b0;
    if9.in_valid  = 1'b0;
    if16.in_valid = 1'b0;
    lat = 1;
    while (!vld_of(sel) && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"},  lat,          exp_lat);
    check({tag, "_data"}, data_of(sel), ed);
    check({tag, "_idx"},  idx_of(sel),  ei);
    check({tag, "_sat"},  sat_of(sel),  es);
    tick();
    check({tag, "_drain"}, vld_of(sel), 0);
  endtask

  initial begin
    rst = 1'b1;
    if9.in_valid  = 1'b0; if9.in_data  = '0; if9.in_mode  = 2'b00; if9.out_ready  = 1'b1;
    if2.in_valid  = 1'b0; if2.in_data  = '0; if2.in_mode  = 2'b00; if2.out_ready  = 1'b1;
    if16.in_valid = 1'b0; if16.in_data = '0; if16.in_mode = 2'b00; if16.out_ready = 1'b1;
    tick(); tick(); tick();

    check("rst_valid",    if9.out_valid, 0);
    check("rst_data",     if9.out_data,  0);
    check("rst_idx",      if9.out_idx,   0);
    check("rst_sat",      if9.out_sat,   0);
    check("rst_in_ready", if9.in_ready,  0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", if9.in_ready, 1);

    // Test 1: max with a tie between elements 2 and 4.
    ev = '{3, -7, 12, 0, 12, 5, -1, 2, 9, 0, 0, 0, 0, 0, 0, 0};
    single(9, "t1_max", 2'b00, 9, 4, 12, 2, 0);

    // Test 2: min winner sits on the unpaired last element.
    ev = '{5, 5, 5, 5, 5, 5, 5, 5, -32768, 0, 0, 0, 0, 0, 0, 0};
    single(9, "t2_min", 2'b01, 9, 4, -32768, 8, 0);

    // Test 3: sum saturating high, and a small negative sum.
    ev = '{30000, 30000, 30000, 30000, 30000, 30000, 30000, 30000, 30000, 0, 0, 0, 0, 0, 0, 0};
    single(9, "t3_sum_sat", 2'b10, 9, 4, 32767, 0, 1);
    ev = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0};
    single(9, "t3_sum_neg", 2'b10, 9, 4, -9, 0, 0);
    ev = '{-30000, -30000, -30000, -30000, -30000, -30000, -30000, -30000, -30000, 0, 0, 0, 0, 0, 0, 0};
    single(9, "t3_sum_satlo", 2'b10, 9, 4, -32768, 0, 1);
    ev = '{1, 4, 4, 2, 0, 4, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0};
    single(9, "t3_rsv_max", 2'b11, 9, 4, 4, 1, 0);

    // Test 4: back-to-back random beats with random backpressure.
    exp_q.delete();
    sent = 0; got = 0; cyc = 0; stalled = 1'b0;
    held_d = 0; held_i = 0; held_s = 0;
    if9.out_ready = 1'b1;
    new_beat9();
    while (got < 20 && cyc < 1000) begin
      @(negedge clk);
      check("t4_in_ready", if9.in_ready, (!if9.out_valid || if9.out_ready));
      if (stalled) begin
        check("t4_hold_valid", if9.out_valid, 1);
        check("t4_hold_data",  if9.out_data,  held_d);
        check("t4_hold_idx",   if9.out_idx,   held_i);
        check("t4_hold_sat",   if9.out_sat,   held_s);
      end
      acc = if9.in_valid && if9.in_ready;
      if (acc) exp_q.push_back(model9(rv, rmode));
      if (if9.out_valid && if9.out_ready) begin
        check("t4_expected_beat", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          check("t4_data", if9.out_data, r.d);
          check("t4_idx",  if9.out_idx,  r.i);
          check("t4_sat",  if9.out_sat,  r.s);
          got++;
        end
      end
      stalled = if9.out_valid && !if9.out_ready;
      held_d  = if9.out_data;
      held_i  = if9.out_idx;
      held_s  = if9.out_sat;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 20) new_beat9();
        else if9.in_valid = 1'b0;
      end
      if9.out_ready = 1'($urandom_range(1));
    end
    check("t4_received", got, 20);
    check("t4_sent", sent, 20);
    check("t4_leftover", exp_q.size(), 0);
    if9.in_valid  = 1'b0;
    if9.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t4_no_extra", if9.out_valid, 0);
    end

    // Test 5: four beats in flight, then a one-cycle reset.
    for (int b = 1; b <= 4; b++) begin
      for (int k = 0; k < 9; k++) ev[k] = b;
      if9.in_data  = pack_ev(9)[143:0];
      if9.in_mode  = 2'b00;
      if9.in_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    if9.in_valid = 1'b0;
    #1;
    check("t5_in_ready_rst", if9.in_ready, 0);
    tick();
    check("t5_valid", if9.out_valid, 0);
    check("t5_data",  if9.out_data,  0);
    check("t5_idx",   if9.out_idx,   0);
    check("t5_sat",   if9.out_sat,   0);
    rst = 1'b0;
    ev = '{1, 2, 3, 100, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0};
    single(9, "t5_after", 2'b00, 9, 4, 100, 3, 0);

    // Test 6: other window sizes.
    ev = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    single(2,  "t6_n2_max",  2'b00, 2,  1, 7, 0, 0);
    single(16, "t6_n16_max", 2'b00, 16, 4, 7, 0, 0);
    single(16, "t6_n16_sum", 2'b10, 16, 4, 112, 0, 0);
    ev = '{5, -3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    single(2,  "t6_n2_min",  2'b01, 2,  1, -3, 1, 0);
    ev = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 2, 9, 3, 9, 4, 5};
    single(16, "t6_n16_idx", 2'b00, 16, 4, 9, 11, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
